alu_muldiv: RTL

Parametrised next-generation execute unit for the datapath. It is registered and handshaked, and adds iterative multiply and divide alongside the full single-cycle op set. Operands enter through a valid/ready request; results leave through a valid/ready response holding a LO result, a HI result, and flags. The EX stage stalls on req_ready/resp_valid, so multi-cycle ops need no hazard logic elsewhere.

---
 rtl/alu_muldiv.sv | 327 ++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_muldiv.sv
// alu_muldiv: registered, handshaked execute unit.
//
// Single-cycle ops (shifts, add/sub, logic, set-less-than) produce a
// response one cycle after the accept edge. MULT/MULTU run a shift-add
// multiplier and DIV/DIVU a restoring divider, one bit per cycle. A final
// FIX cycle applies sign correction and registers the response.
//
// Ports:
//   CLK, nRST            clock, synchronous active-low reset
//   req_valid/req_ready  request handshake (aluop, port_a, port_b)
//   resp_valid/resp_ready response handshake; response held until consumed
//   port_o               result, product low half or quotient
//   port_hi              product high half or remainder (0 for single-cycle)
//   overflow, zero, negative, div_zero  result flags
//
// Build option: define ALU_EARLY_TERM_EN to let MUL stop once the remaining
// multiplier bits are zero and DIV skip leading zero dividend bits. Results
// are the same; only the iterative latency changes.

module alu_muldiv #(
    parameter int WORD_W  = 32,
    parameter int SHAMT_W = $clog2(WORD_W),
    parameter int CNT_W   = $clog2(WORD_W) + 1
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        aluop,
    input  logic [WORD_W-1:0] port_a,
    input  logic [WORD_W-1:0] port_b,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [WORD_W-1:0] port_o,
    output logic [WORD_W-1:0] port_hi,
    output logic              overflow,
    output logic              zero,
    output logic              negative,
    output logic              div_zero
);

    localparam logic [3:0] OP_SLL  = 4'b0000;
    localparam logic [3:0] OP_SRL  = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_OR   = 4'b0101;
    localparam logic [3:0] OP_XOR  = 4'b0110;
    localparam logic [3:0] OP_NOR  = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1010;
    localparam logic [3:0] OP_SLTU = 4'b1011;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2*WORD_W-1:0] acc_q, acc_d;     // product, or {remainder, quotient}
    logic [2*WORD_W-1:0] opb_q, opb_d;     // shifted multiplicand, or divisor
    logic [WORD_W-1:0]   mplr_q, mplr_d;   // remaining multiplier bits
    logic                is_div_q, is_div_d;
    logic                neg_lo_q, neg_lo_d;  // negate product / quotient
    logic                neg_hi_q, neg_hi_d;  // negate remainder
    logic                dz_q, dz_d;
    logic                resp_valid_q, resp_valid_d;
    logic [WORD_W-1:0]   port_o_q, port_o_d;
    logic [WORD_W-1:0]   port_hi_q, port_hi_d;
    logic                ovf_q, ovf_d;
    logic                zero_q, zero_d;
    logic                neg_q, neg_d;
    logic                dzf_q, dzf_d;

    function automatic logic [WORD_W-1:0] magnitude(input logic [WORD_W-1:0] v,
                                                    input logic              sgn);
        return (sgn && v[WORD_W-1]) ? -v : v;
    endfunction

`ifdef ALU_EARLY_TERM_EN
    function automatic logic [CNT_W-1:0] clz(input logic [WORD_W-1:0] v);
        logic [CNT_W-1:0] n;
        logic             found;
        n     = CNT_W'(WORD_W);
        found = 1'b0;
        for (int i = WORD_W - 1; i >= 0; i--) begin
            if (!found && v[i]) begin
                n     = CNT_W'(WORD_W - 1 - i);
                found = 1'b1;
            end
        end
        return n;
    endfunction
`endif

    // Request decode and single-cycle results
    logic                accept;
    logic                is_iter;
    logic                op_signed;
    logic [WORD_W-1:0]   a_mag, b_mag;
    logic [WORD_W-1:0]   sum, dif;
    logic [SHAMT_W-1:0]  shamt;
    logic [WORD_W-1:0]   sc_lo;
    logic                sc_ovf;
    logic                sc_legal;
`ifdef ALU_EARLY_TERM_EN
    logic [CNT_W-1:0]    a_lz;
    assign a_lz = clz(a_mag);
`endif

    assign req_ready = (state_q == IDLE) && (!resp_valid_q || resp_ready);
    assign accept    = req_valid && req_ready;
    assign is_iter   = (aluop[3:2] == 2'b11);
    assign op_signed = ~aluop[0];
    assign a_mag     = magnitude(port_a, op_signed);
    assign b_mag     = magnitude(port_b, op_signed);
    assign sum       = port_a + port_b;
    assign dif       = port_a - port_b;
    assign shamt     = port_b[SHAMT_W-1:0];

    always_comb begin
        sc_lo    = '0;
        sc_ovf   = 1'b0;
        sc_legal = 1'b1;
        case (aluop)
            OP_SLL:  sc_lo = port_a << shamt;
            OP_SRL:  sc_lo = port_a >> shamt;
            OP_ADD: begin
                sc_lo  = sum;
                sc_ovf = (port_a[WORD_W-1] == port_b[WORD_W-1]) &&
                         (sum[WORD_W-1] != port_a[WORD_W-1]);
            end
            OP_SUB: begin
                sc_lo  = dif;
                sc_ovf = (port_a[WORD_W-1] != port_b[WORD_W-1]) &&
                         (dif[WORD_W-1] != port_a[WORD_W-1]);
            end
            OP_AND:  sc_lo = port_a & port_b;
            OP_OR:   sc_lo = port_a | port_b;
            OP_XOR:  sc_lo = port_a ^ port_b;
            OP_NOR:  sc_lo = ~(port_a | port_b);
            OP_SLT:  sc_lo = {{(WORD_W-1){1'b0}}, ($signed(port_a) < $signed(port_b))};
            OP_SLTU: sc_lo = {{(WORD_W-1){1'b0}}, (port_a < port_b)};
            // Illegal codes land here; iterative codes never use sc_*.
            default: sc_legal = 1'b0;
        endcase
    end

    // Iteration datapath
    logic [WORD_W:0]     div_part, div_diff;
    logic [2*WORD_W-1:0] prod_fix;
    logic [WORD_W-1:0]   quo_fix, rem_fix;
    logic [WORD_W-1:0]   res_lo, res_hi;

    // Partial remainder shifted left with the next dividend bit brought in.
    assign div_part = acc_q[2*WORD_W-1:WORD_W-1];
    assign div_diff = div_part - {1'b0, opb_q[WORD_W-1:0]};
    assign prod_fix = neg_lo_q ? -acc_q : acc_q;
    assign quo_fix  = neg_lo_q ? -acc_q[WORD_W-1:0] : acc_q[WORD_W-1:0];
    assign rem_fix  = neg_hi_q ? -acc_q[2*WORD_W-1:WORD_W] : acc_q[2*WORD_W-1:WORD_W];

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        opb_d        = opb_q;
        mplr_d       = mplr_q;
        is_div_d     = is_div_q;
        neg_lo_d     = neg_lo_q;
        neg_hi_d     = neg_hi_q;
        dz_d         = dz_q;
        resp_valid_d = resp_valid_q && !resp_ready;
        port_o_d     = port_o_q;
        port_hi_d    = port_hi_q;
        ovf_d        = ovf_q;
        zero_d       = zero_q;
        neg_d        = neg_q;
        dzf_d        = dzf_q;
        res_lo       = '0;
        res_hi       = '0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!is_iter) begin
                        port_o_d     = sc_lo;
                        port_hi_d    = '0;
                        ovf_d        = sc_ovf;
                        zero_d       = sc_legal && (sc_lo == '0);
                        neg_d        = sc_lo[WORD_W-1];
                        dzf_d        = 1'b0;
                        resp_valid_d = 1'b1;
                    end else begin
                        cnt_d    = '0;
                        dz_d     = 1'b0;
                        is_div_d = aluop[1];
                        neg_lo_d = op_signed && (port_a[WORD_W-1] ^ port_b[WORD_W-1]);
                        if (!aluop[1]) begin
                            acc_d    = '0;
                            opb_d    = {{WORD_W{1'b0}}, a_mag};
                            mplr_d   = b_mag;
                            neg_hi_d = 1'b0;
                            state_d  = MUL;
`ifdef ALU_EARLY_TERM_EN
                            if (b_mag == '0) state_d = FIX;
`endif
                        end else begin
                            opb_d    = {{WORD_W{1'b0}}, b_mag};
                            neg_hi_d = op_signed && port_a[WORD_W-1];
                            if (port_b == '0) begin
                                // Preload the divide-by-zero result; FIX passes it through.
                                dz_d    = 1'b1;
                                acc_d   = {port_a, {WORD_W{1'b1}}};
                                state_d = FIX;
                            end else begin
`ifdef ALU_EARLY_TERM_EN
                                if (a_lz == CNT_W'(WORD_W)) begin
                                    acc_d   = '0;
                                    state_d = FIX;
                                end else begin
                                    // Leading zero bits would only shift zeros into the remainder.
                                    acc_d   = {{WORD_W{1'b0}}, a_mag << a_lz};
                                    cnt_d   = a_lz;
                                    state_d = DIV;
                                end
`else
                                acc_d   = {{WORD_W{1'b0}}, a_mag};
                                state_d = DIV;
`endif
                            end
                        end
                    end
                end
            end

            MUL: begin
                if (mplr_q[0]) acc_d = acc_q + opb_q;
                opb_d  = opb_q << 1;
                mplr_d = mplr_q >> 1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WORD_W - 1)) state_d = FIX;
`ifdef ALU_EARLY_TERM_EN
                if ((mplr_q >> 1) == '0) state_d = FIX;
`endif
            end

            DIV: begin
                if (!div_diff[WORD_W]) begin
                    acc_d = {div_diff[WORD_W-1:0], acc_q[WORD_W-2:0], 1'b1};
                end else begin
                    acc_d = {div_part[WORD_W-1:0], acc_q[WORD_W-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WORD_W - 1)) state_d = FIX;
            end

            FIX: begin
                if (dz_q) begin
                    res_lo = acc_q[WORD_W-1:0];
                    res_hi = acc_q[2*WORD_W-1:WORD_W];
                end else if (is_div_q) begin
                    res_lo = quo_fix;
                    res_hi = rem_fix;
                end else begin
                    res_lo = prod_fix[WORD_W-1:0];
                    res_hi = prod_fix[2*WORD_W-1:WORD_W];
                end
                port_o_d     = res_lo;
                port_hi_d    = res_hi;
                ovf_d        = 1'b0;
                zero_d       = (res_lo == '0);
                neg_d        = res_lo[WORD_W-1];
                dzf_d        = dz_q;
                resp_valid_d = 1'b1;
                state_d      = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    // Control and response registers
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            is_div_q     <= 1'b0;
            neg_lo_q     <= 1'b0;
            neg_hi_q     <= 1'b0;
            dz_q         <= 1'b0;
            resp_valid_q <= 1'b0;
            port_o_q     <= '0;
            port_hi_q    <= '0;
            ovf_q        <= 1'b0;
            zero_q       <= 1'b0;
            neg_q        <= 1'b0;
            dzf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            is_div_q     <= is_div_d;
            neg_lo_q     <= neg_lo_d;
            neg_hi_q     <= neg_hi_d;
            dz_q         <= dz_d;
            resp_valid_q <= resp_valid_d;
            port_o_q     <= port_o_d;
            port_hi_q    <= port_hi_d;
            ovf_q        <= ovf_d;
            zero_q       <= zero_d;
            neg_q        <= neg_d;
            dzf_q        <= dzf_d;
        end
    end

    // Iteration registers: always reloaded at accept, so no reset needed
    always_ff @(posedge CLK) begin
        acc_q  <= acc_d;
        opb_q  <= opb_d;
        mplr_q <= mplr_d;
    end

    assign resp_valid = resp_valid_q;
    assign port_o     = port_o_q;
    assign port_hi    = port_hi_q;
    assign overflow   = ovf_q;
    assign zero       = zero_q;
    assign negative   = neg_q;
    assign div_zero   = dzf_q;

endmodule
